// File: rtl/seq_mul_unit.sv
// seq_mul_unit: shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU driving the shared execute-stage adder.
// Define MUL_EARLY_EXIT_EN to finish CALC as soon as the remaining multiplier bits are all zero.
module seq_mul_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] add_a,
   output logic [XLEN-1:0] add_b,
   input  logic [XLEN-1:0] add_sum,
   input  logic            add_cout
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state_q, state_d;
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d, result_q, result_d;
   logic [CW-1:0] count_q, count_d;
   logic neg_q, neg_d, mul_lo_q, mul_lo_d, busy_q, busy_d, done_q, done_d;
   logic s1, s2;
   logic [XLEN-1:0] m1, m2;
   logic [2*XLEN-1:0] prod;
`ifdef MUL_EARLY_EXIT_EN
   logic [XLEN-1:0] left_mask;
   logic [CW-1:0] rem;
`endif
   always_comb begin
      s1 = (op == 2'b01 || op == 2'b10) && rs1[XLEN-1];
      s2 = op == 2'b01 && rs2[XLEN-1];
      m1 = s1 ? -rs1 : rs1;
      m2 = s2 ? -rs2 : rs2;
      prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      add_a = state_q == CALC ? hi_q : '0;
      add_b = (state_q == CALC && lo_q[0]) ? mcand_q : '0;
`ifdef MUL_EARLY_EXIT_EN
      left_mask = {XLEN{1'b1}} >> count_q;
      rem = CW'(XLEN) - count_q;
`endif
      state_d = state_q;
      hi_d = hi_q;
      lo_d = lo_q;
      mcand_d = mcand_q;
      count_d = count_q;
      neg_d = neg_q;
      mul_lo_d = mul_lo_q;
      result_d = result_q;
      if (state_q == IDLE && start) begin
         state_d = CALC;
         hi_d = '0;
         lo_d = m2;
         mcand_d = m1;
         count_d = '0;
         neg_d = s1 ^ s2;
         mul_lo_d = op == 2'b00;
      end else if (state_q == CALC) begin
`ifdef MUL_EARLY_EXIT_EN
         // Low XLEN-count bits of lo are the unconsumed multiplier bits
         if ((lo_q & left_mask) == '0) begin
            {hi_d, lo_d} = {hi_q, lo_q} >> rem;
            state_d = FIX;
         end else
`endif
         begin
            {hi_d, lo_d} = {add_cout, add_sum, lo_q[XLEN-1:1]};
            count_d = count_q + 1'b1;
            state_d = count_q == LAST ? FIX : CALC;
         end
      end else if (state_q == FIX) begin
         result_d = mul_lo_q ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
         state_d = DONE;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
      busy_d = state_d == CALC || state_d == FIX;
      done_d = state_d == DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hi_q <= '0;
         lo_q <= '0;
         mcand_q <= '0;
         count_q <= '0;
         neg_q <= 1'b0;
         mul_lo_q <= 1'b0;
         result_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
         mcand_q <= mcand_d;
         count_q <= count_d;
         neg_q <= neg_d;
         mul_lo_q <= mul_lo_d;
         result_q <= result_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign result = result_q;
endmodule

// File: doc/seq_mul_unit.md
Name: seq_mul_unit

Overview:
- Multi-cycle shift-add multiplier for the RV32M MUL, MULH, MULHSU and MULHU instructions.
- Sits directly upstream of the shared ripple-carry adder in the execute stage. It drives the adder operands each cycle and consumes the adder's sum and carry-out to accumulate partial products.
- The adder is a purely combinational neighbour: its sum is valid in the same cycle the operands are driven.

Parameters:
XLEN, 32, operand and result width; must be ≥ 4.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
rs1  in  XLEN  multiplicand
rs2  in  XLEN  multiplier
busy  out  1  high in CALC and FIX
done  out  1  one-cycle pulse; result valid
result  out  XLEN  low word (MUL) or high word (others); held until next accepted start
add_a  out  XLEN  adder operand A
add_b  out  XLEN  adder operand B
add_sum  in  XLEN  adder sum
add_cout  in  1  adder carry-out

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - State is IDLE.
  - busy=0, done=0, result=0, add_a=0, add_b=0.
  - All internal registers are cleared.
  - rst has priority over every other input, including mid-CALC; the operation is abandoned with no done pulse.
- States: IDLE → CALC → FIX → DONE → IDLE.
- IDLE, with start=1 sampled at edge of cycle t:
  - Capture magnitudes: |rs1| if rs1 is signed for op (MULH, MULHSU); |rs2| if rs2 is signed (MULH only).
  - neg = XOR of the operand signs actually treated as signed.
  - hi=0, carry=0, lo=|rs2|, mcand=|rs1|, count=0.
  - Go to CALC.
- CALC, one iteration per cycle:
  - add_a=hi; add_b = lo[0] ? mcand : 0.
  - {carry,hi,lo} ← {add_cout, add_sum, lo} >> 1.
  - count increments; after XLEN iterations go to FIX.
  - add_a and add_b are 0 in all states other than CALC.
- FIX (single cycle):
  - If neg, the 2·XLEN product {hi,lo} is two's-complemented by internal logic; the external adder is not used.
  - result ← low word for MUL, high word otherwise.
- DONE: done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency without the optional feature: CALC occupies cycles t+1..t+XLEN, FIX is t+XLEN+1, done is high in cycle t+XLEN+2 (t+34 for XLEN=32).
- start is ignored outside IDLE. It is not queued, and the in-flight operation is unaffected.
- start in the DONE cycle is ignored. The earliest next accept is the cycle after done.
- Operand edge cases:
  - The most-negative operand (0x80000000) magnitude is 2^(XLEN-1); it is held unsigned in XLEN bits, so there is no overflow.
  - A zero operand with neg=1 yields a zero product (negating zero gives zero).
- rs1, rs2 and op are don't-care after the capture cycle.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - At the start of each CALC cycle, check whether the unconsumed multiplier bits lo[XLEN-1-count:0] are all zero.
  - If so, perform no add. {carry,hi,lo} is shifted right by the remaining (XLEN-count) positions in that cycle, then go to FIX.
  - CALC length C = min(msb_index(|rs2|)+2, XLEN); C=1 when |rs2|=0. done is in cycle t+C+2.
- Undefined: fixed C=XLEN. Results must be identical in both builds.

Test Plan:
- MUL, rs1=7, rs2=6, start at cycle t → result=0x0000002A with done=1 at t+34; busy high in cycles t+1..t+33. With MUL_EARLY_EXIT_EN: done at t+6 (msb of 6 is 2, so C=4).
- All four ops with rs1=rs2=0xFFFFFFFF → MUL 0x00000001; MULH 0x00000000; MULHU 0xFFFFFFFE; MULHSU 0xFFFFFFFF.
- MULH, rs1=rs2=0x80000000 → result 0x40000000. MUL, rs1=0x80000000, rs2=0xFFFFFFFF → 0x80000000.
- start pulsed with new operands at t+5 while busy → ignored; the original result is unchanged and a single done pulse occurs at t+34.
- rst=1 during cycle t+10 of CALC → next cycle busy=0, done=0, result=0, add_a=add_b=0, with no done pulse. A fresh MUL 3×5 afterwards returns 0x0000000F.
- MUL_EARLY_EXIT_EN, MUL rs1=0x12345678, rs2=0 → result 0 with done at t+3. Same op with rs2=0x80000000 → C=32, result 0x00000000, done at t+34.
